// File: rtl/bus_if_types_pkg.sv
// Shared bus field types plus the arbiter's owner and state encodings.
package bus_if_types_pkg;

  typedef enum logic {READ = 1'b0, WRITE = 1'b1} ttype_e;
  typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} tsize_e;

  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_I = 2'd1, OWN_D = 2'd2} bus_owner_e;
  typedef enum logic [1:0] {IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2} arb_state_e;

  function automatic arb_state_e grant_of(input bus_owner_e o);
    case (o)
      OWN_I:   grant_of = GNT_I;
      OWN_D:   grant_of = GNT_D;
      default: grant_of = IDLE;
    endcase
  endfunction

endpackage

// File: rtl/master_bus_if.sv
// Core-side bus bundle; the master modport drives the request fields, the slave answers.
interface master_bus_if;
  import bus_if_types_pkg::*;

  logic        breq;
  logic        bstart;
  ttype_e      ttype;
  tsize_e      tsize;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        bdone;

  modport master (output breq, bstart, ttype, tsize, addr, wdata, input rdata, bdone);
  modport slave  (input breq, bstart, ttype, tsize, addr, wdata, output rdata, bdone);

endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker; req[0] is ibus, req[1] is dbus.
module rr_pick2
  import bus_if_types_pkg::*;
#(
  parameter bit DBUS_FIRST = 1'b1
) (
  input  logic [1:0] req,
  input  bus_owner_e last,
  output bus_owner_e pick
);

  always_comb begin
    pick = OWN_NONE;
    case (req)
      2'b01: pick = OWN_I;
      2'b10: pick = OWN_D;
      2'b11: begin
        // Favour whoever was not served last; with no history fall back to the tie-break.
        if (last == OWN_I)      pick = OWN_D;
        else if (last == OWN_D) pick = OWN_I;
        else                    pick = DBUS_FIRST ? OWN_D : OWN_I;
      end
      default: pick = OWN_NONE;
    endcase
  end

endmodule

// File: rtl/bus_arbiter_2m.sv
// Merges ibus and dbus onto one shared bus with transfer-atomic round-robin ownership.
module bus_arbiter_2m
  import bus_if_types_pkg::*;
#(
  parameter bit DBUS_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  master_bus_if.slave  ibus_s,
  master_bus_if.slave  dbus_s,
  master_bus_if.master sbus,
  output bus_owner_e owner
);

  arb_state_e state;
  bus_owner_e last;
  bus_owner_e pick_last;
  bus_owner_e pick;
  logic       req_i;
  logic       req_d;

  assign req_i = ibus_s.breq & ibus_s.bstart;
  assign req_d = dbus_s.breq & dbus_s.bstart;

  // While granted, the current owner counts as "last" so completion hands off to the other master.
  always_comb begin
    case (state)
      GNT_I:   pick_last = OWN_I;
      GNT_D:   pick_last = OWN_D;
      default: pick_last = last;
    endcase
  end

  rr_pick2 #(.DBUS_FIRST(DBUS_FIRST)) u_pick (
    .req  ({req_d, req_i}),
    .last (pick_last),
    .pick (pick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= OWN_NONE;
      last  <= DBUS_FIRST ? OWN_I : OWN_D;
    end else begin
      case (state)
        IDLE: begin
          state <= grant_of(pick);
          owner <= pick;
        end
        GNT_I, GNT_D: begin
          if (sbus.bdone) begin
            last  <= pick_last;
            state <= grant_of(pick);
            owner <= pick;
          end
        end
        default: begin
          state <= IDLE;
          owner <= OWN_NONE;
        end
      endcase
    end
  end

  always_comb begin
    sbus.breq     = 1'b0;
    sbus.bstart   = 1'b0;
    sbus.ttype    = READ;
    sbus.tsize    = WORD;
    sbus.addr     = '0;
    sbus.wdata    = '0;
    ibus_s.bdone  = 1'b0;
    dbus_s.bdone  = 1'b0;
    case (state)
      GNT_I: begin
        sbus.breq    = ibus_s.breq;
        sbus.bstart  = ibus_s.bstart;
        sbus.ttype   = ibus_s.ttype;
        sbus.tsize   = ibus_s.tsize;
        sbus.addr    = ibus_s.addr;
        sbus.wdata   = ibus_s.wdata;
        ibus_s.bdone = sbus.bdone;
      end
      GNT_D: begin
        sbus.breq    = dbus_s.breq;
        sbus.bstart  = dbus_s.bstart;
        sbus.ttype   = dbus_s.ttype;
        sbus.tsize   = dbus_s.tsize;
        sbus.addr    = dbus_s.addr;
        sbus.wdata   = dbus_s.wdata;
        dbus_s.bdone = sbus.bdone;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; each master qualifies it with its own bdone.
  assign ibus_s.rdata = sbus.rdata;
  assign dbus_s.rdata = sbus.rdata;

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// Scoreboard bench: directed master traffic, a latency-programmable slave, and a transfer monitor.
module tb_bus_arbiter_2m;
  import bus_if_types_pkg::*;

  typedef struct {
    bus_owner_e  own;
    ttype_e      tt;
    tsize_e      ts;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } xfer_t;

  logic       clk;
  logic       rst_n;
  bus_owner_e owner;

  master_bus_if ibus ();
  master_bus_if dbus ();
  master_bus_if sbus ();

  bus_arbiter_2m #(.DBUS_FIRST(1'b1)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ibus_s (ibus),
    .dbus_s (dbus),
    .sbus   (sbus),
    .owner  (owner)
  );

  xfer_t exq[$];
  xfer_t iq[$];
  xfer_t dq[$];
  xfer_t cur_i;
  xfer_t cur_d;
  logic  i_act, d_act;
  int    n_chk = 0;
  int    n_fail = 0;
  int    slv_lat = 2;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic txn(input bus_owner_e who, input ttype_e tt, input tsize_e ts,
                     input logic [31:0] a, input logic [31:0] w);
    xfer_t x;
    x.own = who; x.tt = tt; x.ts = ts; x.addr = a; x.wdata = w; x.rdata = '0;
    if (who == OWN_I) iq.push_back(x);
    else dq.push_back(x);
  endtask

  task automatic expect_xfer(input bus_owner_e who, input ttype_e tt, input tsize_e ts,
                             input logic [31:0] a, input logic [31:0] w, input logic [31:0] r);
    xfer_t x;
    x.own = who; x.tt = tt; x.ts = ts; x.addr = a; x.wdata = w; x.rdata = r;
    exq.push_back(x);
  endtask

  task automatic wait_idle(input int budget);
    logic done;
    done = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      #3;
      if (exq.size() == 0 && iq.size() == 0 && dq.size() == 0 && !i_act && !d_act) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain_within_budget", {31'd0, done}, 32'd1);
  endtask

  // Masters: hold a request until their own bdone, then drop or load the next one before the edge.
  initial begin
    logic ib, db;
    i_act = 1'b0; d_act = 1'b0;
    cur_i = '{OWN_I, READ, WORD, 32'd0, 32'd0, 32'd0};
    cur_d = '{OWN_D, READ, WORD, 32'd0, 32'd0, 32'd0};
    forever begin
      ibus.breq = i_act; ibus.bstart = i_act; ibus.ttype = cur_i.tt; ibus.tsize = cur_i.ts;
      ibus.addr = cur_i.addr; ibus.wdata = cur_i.wdata;
      dbus.breq = d_act; dbus.bstart = d_act; dbus.ttype = cur_d.tt; dbus.tsize = cur_d.ts;
      dbus.addr = cur_d.addr; dbus.wdata = cur_d.wdata;
      @(negedge clk);
      ib = ibus.bdone;
      db = dbus.bdone;
      #1;
      if (!rst_n) begin
        i_act = 1'b0; d_act = 1'b0;
        iq.delete(); dq.delete();
      end
      if (i_act && ib) i_act = 1'b0;
      if (d_act && db) d_act = 1'b0;
      if (rst_n && !i_act && iq.size() > 0) begin cur_i = iq.pop_front(); i_act = 1'b1; end
      if (rst_n && !d_act && dq.size() > 0) begin cur_d = dq.pop_front(); d_act = 1'b1; end
    end
  end

  // Slave: bdone arrives in the slv_lat-th cycle of bstart, with rdata = addr + 0x13.
  initial begin
    logic bs, bd;
    int   cnt;
    cnt = 0;
    sbus.bdone = 1'b0;
    sbus.rdata = '0;
    forever begin
      @(negedge clk);
      bs = sbus.bstart;
      bd = sbus.bdone;
      @(posedge clk);
      #1;
      if (!rst_n || bd) begin
        sbus.bdone = 1'b0; sbus.rdata = '0; cnt = 0;
      end else if (bs) begin
        cnt++;
        if (cnt >= slv_lat - 1) begin
          sbus.bdone = 1'b1;
          sbus.rdata = sbus.addr + 32'h13;
        end
      end
    end
  end

  // Monitor: every completed transfer is matched against the next expected one.
  always @(negedge clk) begin
    bus_owner_e  got;
    xfer_t       e;
    logic [31:0] rd;
    if (rst_n && sbus.bdone) begin
      got = (ibus.bdone && !dbus.bdone) ? OWN_I :
            (dbus.bdone && !ibus.bdone) ? OWN_D : OWN_NONE;
      if (exq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_xfer: got owner %0d addr %h expected no transfer", got, sbus.addr);
      end else begin
        e = exq.pop_front();
        chk("xfer_bdone_route", got, e.own);
        chk("xfer_owner_port", owner, e.own);
        chk("xfer_addr", sbus.addr, e.addr);
        chk("xfer_ttype", sbus.ttype, e.tt);
        chk("xfer_tsize", sbus.tsize, e.ts);
        if (e.tt == WRITE) begin
          chk("xfer_wdata", sbus.wdata, e.wdata);
        end else begin
          rd = (e.own == OWN_I) ? ibus.rdata : dbus.rdata;
          chk("xfer_rdata", rd, e.rdata);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_bstart", sbus.bstart, 0);
    chk("rst_breq", sbus.breq, 0);
    chk("rst_addr", sbus.addr, 0);
    chk("rst_wdata", sbus.wdata, 0);
    chk("rst_ttype", sbus.ttype, READ);
    chk("rst_tsize", sbus.tsize, WORD);
    chk("rst_owner", owner, OWN_NONE);
    chk("rst_bdone", {30'd0, ibus.bdone, dbus.bdone}, 0);
    #2 rst_n = 1'b1;

    // Single ibus read, also measuring IDLE arbitration latency.
    slv_lat = 3;
    @(negedge clk); #2;
    txn(OWN_I, READ, WORD, 32'h0000_0000, 32'd0);
    expect_xfer(OWN_I, READ, WORD, 32'h0000_0000, 32'd0, 32'h0000_0013);
    @(negedge clk); #2;
    chk("lat_no_comb_grant", sbus.bstart, 0);
    chk("lat_owner_still_none", owner, OWN_NONE);
    @(negedge clk);
    chk("lat_grant_bstart", sbus.bstart, 1);
    chk("lat_grant_owner", owner, OWN_I);
    wait_idle(50);
    @(negedge clk);
    chk("s1_back_to_idle", owner, OWN_NONE);

    // Contention straight out of reset: dbus wins, ibus follows with no idle cycle.
    @(negedge clk); #2 rst_n = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
    slv_lat = 2;
    @(negedge clk); #2;
    txn(OWN_I, READ, WORD, 32'h0000_0004, 32'd0);
    txn(OWN_D, WRITE, WORD, 32'h1000_0000, 32'hDEAD_BEEF);
    expect_xfer(OWN_D, WRITE, WORD, 32'h1000_0000, 32'hDEAD_BEEF, 32'd0);
    expect_xfer(OWN_I, READ, WORD, 32'h0000_0004, 32'd0, 32'h0000_0017);
    @(negedge clk); #2;
    @(negedge clk);
    chk("tie_first_owner", owner, OWN_D);
    chk("tie_first_addr", sbus.addr, 32'h1000_0000);
    chk("tie_first_wdata", sbus.wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    @(negedge clk);
    chk("handoff_owner", owner, OWN_I);
    chk("handoff_bstart", sbus.bstart, 1);
    chk("handoff_addr", sbus.addr, 32'h0000_0004);
    wait_idle(50);

    // Continuous contention: grants alternate D, I, D, I, D, then the last ibus read.
    slv_lat = 3;
    @(negedge clk); #2;
    txn(OWN_I, READ, WORD, 32'h0000_0100, 32'd0);
    txn(OWN_I, READ, WORD, 32'h0000_0104, 32'd0);
    txn(OWN_I, READ, WORD, 32'h0000_0108, 32'd0);
    txn(OWN_D, READ, WORD, 32'h2000_0010, 32'd0);
    txn(OWN_D, READ, WORD, 32'h2000_0014, 32'd0);
    txn(OWN_D, READ, WORD, 32'h2000_0018, 32'd0);
    expect_xfer(OWN_D, READ, WORD, 32'h2000_0010, 32'd0, 32'h2000_0023);
    expect_xfer(OWN_I, READ, WORD, 32'h0000_0100, 32'd0, 32'h0000_0113);
    expect_xfer(OWN_D, READ, WORD, 32'h2000_0014, 32'd0, 32'h2000_0027);
    expect_xfer(OWN_I, READ, WORD, 32'h0000_0104, 32'd0, 32'h0000_0117);
    expect_xfer(OWN_D, READ, WORD, 32'h2000_0018, 32'd0, 32'h2000_002B);
    expect_xfer(OWN_I, READ, WORD, 32'h0000_0108, 32'd0, 32'h0000_011B);
    wait_idle(200);

    // Atomicity: dbus arrives during a 5-cycle ibus transfer and must wait for bdone.
    slv_lat = 5;
    @(negedge clk); #2;
    txn(OWN_I, READ, WORD, 32'h0000_0200, 32'd0);
    expect_xfer(OWN_I, READ, WORD, 32'h0000_0200, 32'd0, 32'h0000_0213);
    expect_xfer(OWN_D, READ, WORD, 32'h2000_0100, 32'd0, 32'h2000_0113);
    @(negedge clk); #2;
    @(negedge clk); #2;
    txn(OWN_D, READ, WORD, 32'h2000_0100, 32'd0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("atomic_addr", sbus.addr, 32'h0000_0200);
      chk("atomic_owner", owner, OWN_I);
    end
    @(negedge clk);
    chk("atomic_next_owner", owner, OWN_D);
    chk("atomic_next_addr", sbus.addr, 32'h2000_0100);
    wait_idle(60);

    // Byte-size pass-through.
    slv_lat = 2;
    @(negedge clk); #2;
    txn(OWN_D, READ, BYTE, 32'h2000_0003, 32'd0);
    expect_xfer(OWN_D, READ, BYTE, 32'h2000_0003, 32'd0, 32'h2000_0016);
    @(negedge clk); #2;
    @(negedge clk);
    chk("byte_tsize", sbus.tsize, BYTE);
    chk("byte_addr", sbus.addr, 32'h2000_0003);
    wait_idle(50);

    // Asynchronous reset in the middle of a dbus write abandons it.
    slv_lat = 6;
    @(negedge clk); #2;
    txn(OWN_D, WRITE, WORD, 32'h3000_0000, 32'h1234_5678);
    @(negedge clk); #2;
    @(negedge clk);
    chk("mid_owner_before_rst", owner, OWN_D);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_bstart", sbus.bstart, 0);
    chk("async_rst_owner", owner, OWN_NONE);
    chk("async_rst_addr", sbus.addr, 0);
    chk("async_rst_dbdone", dbus.bdone, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    slv_lat = 2;
    @(negedge clk); #2;
    txn(OWN_I, READ, WORD, 32'h0000_0300, 32'd0);
    txn(OWN_D, READ, WORD, 32'h2000_0200, 32'd0);
    expect_xfer(OWN_D, READ, WORD, 32'h2000_0200, 32'd0, 32'h2000_0213);
    expect_xfer(OWN_I, READ, WORD, 32'h0000_0300, 32'd0, 32'h0000_0313);
    @(negedge clk); #2;
    @(negedge clk);
    chk("post_rst_first_owner", owner, OWN_D);
    wait_idle(50);

    chk("scoreboard_empty", exq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
